// File: rtl/adc_sample_scheduler.sv
// Captures per-channel ADC samples into holding registers and serves them one at a
// time to a shared PID core through a round-robin arbiter with a valid/ready handshake.
module adc_sample_scheduler #(
    parameter int W_DATA = 18,
    parameter int N_CHAN = 6,
    parameter int W_CHAN = 3
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic [N_CHAN-1:0]        data_valid_in,
    input  logic signed [W_DATA-1:0] data_a_in,
    input  logic signed [W_DATA-1:0] data_b_in,
    input  logic [N_CHAN-1:0]        chan_en_in,
    input  logic                     update_in,
    input  logic                     pid_ready_in,
    input  logic                     ovr_clear_in,
    output logic                     pid_valid_out,
    output logic [W_CHAN-1:0]        pid_chan_out,
    output logic signed [W_DATA-1:0] pid_data_out,
    output logic [N_CHAN-1:0]        chan_en_out,
    output logic [N_CHAN-1:0]        overrun_out
);

    localparam int HALF = N_CHAN / 2;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    logic [0:0]               state_q, state_d;
    logic [W_CHAN-1:0]        last_q, last_d;
    logic [N_CHAN-1:0]        pend_q, pend_d;
    logic [N_CHAN-1:0]        en_q, en_d;
    logic [N_CHAN-1:0]        ovr_q, ovr_d;
    logic                     vld_q, vld_d;
    logic [W_CHAN-1:0]        chan_q, chan_d;
    logic signed [W_DATA-1:0] data_q, data_d;
    logic signed [W_DATA-1:0] hold_q [N_CHAN];
    logic signed [W_DATA-1:0] hold_d [N_CHAN];

    logic [N_CHAN-1:0] cap;
    logic [N_CHAN-1:0] gnt_oh;
    logic [W_CHAN-1:0] gnt_idx;
    logic              gnt_vld;
    logic              arb_go;

    always_comb begin
        cap     = data_valid_in & en_q;
        arb_go  = (state_q == ST_IDLE) || pid_ready_in;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        // Scan from farthest to nearest so the nearest pending channel after last_q wins.
        for (int k = N_CHAN; k >= 1; k--) begin
            int idx;
            idx = (int'(last_q) + k) % N_CHAN;
            if (pend_q[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = W_CHAN'(idx);
            end
        end
        if (arb_go && gnt_vld) gnt_oh[gnt_idx] = 1'b1;

        // A capture on the granted channel re-arms pending; the mask update has final say.
        pend_d = (pend_q & ~gnt_oh) | cap;
        if (update_in) pend_d = pend_d & chan_en_in;

        en_d  = update_in ? chan_en_in : en_q;
        ovr_d = (ovr_clear_in ? '0 : ovr_q) | (cap & pend_q & ~gnt_oh);

        for (int i = 0; i < N_CHAN; i++) begin
            hold_d[i] = hold_q[i];
            if (cap[i]) hold_d[i] = (i < HALF) ? data_a_in : data_b_in;
        end

        state_d = state_q;
        last_d  = last_q;
        vld_d   = vld_q;
        chan_d  = chan_q;
        data_d  = data_q;
        if (arb_go) begin
            if (gnt_vld) begin
                data_d  = hold_q[gnt_idx];
                chan_d  = gnt_idx;
                vld_d   = 1'b1;
                last_d  = gnt_idx;
                state_d = ST_PRESENT;
            end else begin
                vld_d   = 1'b0;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            last_q  <= W_CHAN'(N_CHAN - 1);
            pend_q  <= '0;
            en_q    <= '0;
            ovr_q   <= '0;
            vld_q   <= 1'b0;
            chan_q  <= '0;
            data_q  <= '0;
            for (int i = 0; i < N_CHAN; i++) hold_q[i] <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            en_q    <= en_d;
            ovr_q   <= ovr_d;
            vld_q   <= vld_d;
            chan_q  <= chan_d;
            data_q  <= data_d;
            for (int i = 0; i < N_CHAN; i++) hold_q[i] <= hold_d[i];
        end
    end

    assign pid_valid_out = vld_q;
    assign pid_chan_out  = chan_q;
    assign pid_data_out  = data_q;
    assign chan_en_out   = en_q;
    assign overrun_out   = ovr_q;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench for adc_sample_scheduler: capture, round-robin order, backpressure,
// enable masking, grant/capture collision, reset and overrun-clear priority.
module tb_adc_sample_scheduler;

    logic               clk_in = 1'b0;
    logic               reset_in = 1'b0;
    logic [5:0]         data_valid_in = '0;
    logic signed [17:0] data_a_in = '0;
    logic signed [17:0] data_b_in = '0;
    logic [5:0]         chan_en_in = '0;
    logic               update_in = 1'b0;
    logic               pid_ready_in = 1'b0;
    logic               ovr_clear_in = 1'b0;
    logic               pid_valid_out;
    logic [2:0]         pid_chan_out;
    logic signed [17:0] pid_data_out;
    logic [5:0]         chan_en_out;
    logic [5:0]         overrun_out;

    int n_chk = 0;
    int n_err = 0;

    adc_sample_scheduler dut (
        .clk_in(clk_in), .reset_in(reset_in), .data_valid_in(data_valid_in),
        .data_a_in(data_a_in), .data_b_in(data_b_in), .chan_en_in(chan_en_in),
        .update_in(update_in), .pid_ready_in(pid_ready_in), .ovr_clear_in(ovr_clear_in),
        .pid_valid_out(pid_valid_out), .pid_chan_out(pid_chan_out), .pid_data_out(pid_data_out),
        .chan_en_out(chan_en_out), .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Present check: valid high with given channel and signed data.
    task automatic pres(input string tag, input int ch, input int d);
        chk({tag, ".vld"}, int'(pid_valid_out), 1);
        chk({tag, ".chan"}, int'(pid_chan_out), ch);
        chk({tag, ".data"}, int'($signed(pid_data_out)), d);
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
    endtask

    task automatic set_mask(input logic [5:0] m);
        chan_en_in = m;
        update_in  = 1'b1;
        tick();
        update_in  = 1'b0;
    endtask

    task automatic strobe(input logic [5:0] dv, input int a, input int b);
        data_valid_in = dv;
        data_a_in     = 18'(a);
        data_b_in     = 18'(b);
        tick();
        data_valid_in = '0;
    endtask

    initial begin
        do_reset();
        tick();
        chk("rst.vld", int'(pid_valid_out), 0);
        chk("rst.chan", int'(pid_chan_out), 0);
        chk("rst.data", int'($signed(pid_data_out)), 0);
        chk("rst.en", int'(chan_en_out), 0);
        chk("rst.ovr", int'(overrun_out), 0);

        // 1: basic capture and grant order
        set_mask(6'h3F);
        chk("t1.en", int'(chan_en_out), 'h3F);
        pid_ready_in = 1'b1;
        strobe(6'b001001, 100, -5);
        chk("t1.lat", int'(pid_valid_out), 0);
        tick(); pres("t1.g0", 0, 100);
        tick(); pres("t1.g1", 3, -5);
        tick(); chk("t1.idle", int'(pid_valid_out), 0);

        // 2: round-robin with wrap
        do_reset();
        set_mask(6'h3F);
        strobe(6'h3F, 10, 20);
        for (int c = 0; c < 6; c++) begin
            tick(); pres("t2.rr", c, (c < 3) ? 10 : 20);
        end
        tick(); chk("t2.idle", int'(pid_valid_out), 0);
        strobe(6'b000101, 30, 0);
        tick(); pres("t2.w0", 0, 30);
        tick(); pres("t2.w2", 2, 30);
        tick(); chk("t2.idle2", int'(pid_valid_out), 0);

        // 3: backpressure and overrun
        pid_ready_in = 1'b0;
        strobe(6'b000001, 40, 0);
        tick(); pres("t3.p0", 0, 40);
        strobe(6'b000010, 7, 0);
        chk("t3.noovr", int'(overrun_out), 0);
        strobe(6'b000010, 9, 0);
        chk("t3.ovr", int'(overrun_out), 'b000010);
        for (int i = 0; i < 8; i++) begin
            tick(); pres("t3.stall", 0, 40);
        end
        pid_ready_in = 1'b1;
        tick(); pres("t3.p1", 1, 9);
        tick(); chk("t3.idle", int'(pid_valid_out), 0);
        chk("t3.ovrkeep", int'(overrun_out), 'b000010);
        ovr_clear_in = 1'b1;
        tick();
        ovr_clear_in = 1'b0;
        chk("t3.clr", int'(overrun_out), 0);

        // 4: disabled channel, then mask update drops a pending channel
        set_mask(6'h3E);
        strobe(6'b000001, 50, 0);
        tick(); tick();
        chk("t4.novld", int'(pid_valid_out), 0);
        chk("t4.noovr", int'(overrun_out), 0);
        pid_ready_in = 1'b0;
        strobe(6'b000010, 60, 0);
        tick(); pres("t4.p1", 1, 60);
        strobe(6'b010000, 0, 70);
        set_mask(6'h2F);
        chk("t4.en", int'(chan_en_out), 'h2F);
        pres("t4.keep", 1, 60);
        pid_ready_in = 1'b1;
        tick(); chk("t4.drop", int'(pid_valid_out), 0);
        tick(); chk("t4.drop2", int'(pid_valid_out), 0);

        // 5: grant/capture collision on channel 1
        set_mask(6'h3F);
        pid_ready_in = 1'b0;
        strobe(6'b000001, 5, 0);
        tick(); pres("t5.p0", 0, 5);
        strobe(6'b000010, 11, 0);
        pid_ready_in = 1'b1;
        strobe(6'b000010, 22, 0);
        pres("t5.old", 1, 11);
        chk("t5.noovr", int'(overrun_out), 0);
        tick(); pres("t5.new", 1, 22);
        tick(); chk("t5.idle", int'(pid_valid_out), 0);
        chk("t5.noovr2", int'(overrun_out), 0);

        // 6: reset mid-presentation, then clear-vs-set priority
        pid_ready_in = 1'b0;
        strobe(6'h3F, 1, 2);
        tick(); pres("t6.pre", 2, 1);
        do_reset();
        chk("t6.vld", int'(pid_valid_out), 0);
        chk("t6.en", int'(chan_en_out), 0);
        chk("t6.ovr", int'(overrun_out), 0);
        set_mask(6'h3F);
        pid_ready_in = 1'b1;
        strobe(6'h3F, 1, 2);
        tick(); pres("t6.first", 0, 1);
        for (int i = 0; i < 6; i++) tick();
        chk("t6.idle", int'(pid_valid_out), 0);
        pid_ready_in = 1'b0;
        strobe(6'b001000, 0, 3);
        tick(); pres("t6.p3", 3, 3);
        strobe(6'b000001, 4, 0);
        ovr_clear_in = 1'b1;
        strobe(6'b000001, 5, 0);
        chk("t6.setwins", int'(overrun_out), 'b000001);
        tick();
        ovr_clear_in = 1'b0;
        chk("t6.clr", int'(overrun_out), 0);
        pid_ready_in = 1'b1;
        tick(); pres("t6.p0", 0, 5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
